brg_xcel_load_tracker: RTL
==========================

# brg_xcel_load_tracker

- Sits between an accelerator's master memory port and the manycore endpoint's outgoing-request / returned-data interface.
- Tags each outgoing remote load with a locally allocated load ID from a free pool of `els_p` entries, and records the accelerator's opaque tag for that load.
- On return, maps the load ID back to the opaque tag and delivers the response one cycle later.
- Caps outstanding loads at `els_p`; stores pass through untracked.

## Interface
Parameters:
- `data_width_p`, 32, data width of requests and responses.
- `addr_width_p`, 32, request address width.
- `load_id_width_p`, 11, width of the endpoint load-ID field.
- `opq_width_p`, 8, width of the accelerator's opaque tag.
- `els_p`, 8, tracker entries. Power of two, 2..2^`load_id_width_p`.

Ports:
- Clock and reset: one clock, `clk_i`; reset `reset_i` is synchronous and active-high.
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous active-high reset.
- `xcel_req_val_i` in 1: accelerator request valid.
- `xcel_req_rdy_o` out 1: request accepted this cycle when high with valid.
- `xcel_req_type_i` in 1: 1 = store, 0 = load.
- `xcel_req_addr_i` in `addr_width_p`: request address.
- `xcel_req_data_i` in `data_width_p`: store data.
- `xcel_req_mask_i` in `data_width_p/8`: byte mask.
- `xcel_req_opq_i` in `opq_width_p`: load opaque tag.
- `out_v_o` out 1: request to endpoint / packet encoder.
- `out_ready_i` in 1: endpoint ready.
- `out_type_o` out 1: request type.
- `out_addr_o` out `addr_width_p`: request address.
- `out_data_o` out `data_width_p`: request data.
- `out_mask_o` out `data_width_p/8`: request mask.
- `out_load_id_o` out `load_id_width_p`: allocated ID, zero-extended; 0 for stores.
- `returned_v_i` in 1: load response from endpoint. Always consumed; the caller ties yumi to it.
- `returned_load_id_i` in `load_id_width_p`: ID of the returning load.
- `returned_data_i` in `data_width_p`: returned load data.
- `xcel_resp_val_o` out 1: response to accelerator. The accelerator is always ready.
- `xcel_resp_opq_o` out `opq_width_p`: original opaque tag.
- `xcel_resp_data_o` out `data_width_p`: response data.
- `outstanding_o` out `$clog2(els_p+1)`: number of in-use entries.
- `err_o` out 1: sticky flag for a response to a free or out-of-range ID.

## Operation
- **State:**
  - `inuse_r[els_p]` bitmap.
  - `opq_r[els_p]` tag table.
  - Response register (val/opq/data).
  - `outstanding_r` counter.
  - `err_r`.
- **Allocation:**
  - `alloc_idx` is the lowest index with `inuse_r` = 0, computed from registered state only.
  - `full` = all `inuse_r` bits set.
- **Request path:** combinational pass-through.
  - `out_v_o` = `xcel_req_val_i` & (type = store | !`full`).
  - `xcel_req_rdy_o` = `out_ready_i` & (type = store | !`full`).
  - Addr, data, mask and type are forwarded unchanged.
- **Load fire** (val & rdy & type = 0):
  - `inuse_r[alloc_idx]` <= 1.
  - `opq_r[alloc_idx]` <= `xcel_req_opq_i`.
  - `out_load_id_o` = `alloc_idx`.
- **Store fire:** no tracker state change.
- **Return** (`returned_v_i`):
  - Entry i = `returned_load_id_i`.
  - If i < `els_p` and `inuse_r[i]`:
    - `inuse_r[i]` <= 0.
    - Response register <= {1, `opq_r[i]`, `returned_data_i`}.
  - Otherwise: `err_r` <= 1 and no response is produced.
- **Simultaneous load fire and return:**
  - Both update.
  - A freed entry is not reallocatable until the next cycle, because `alloc_idx` uses pre-update state.
  - `outstanding_r` is net unchanged.
- **`outstanding_r`:** +1 on load fire, −1 on valid free. It never exceeds `els_p`.
- **Head-of-line:** a blocked load holds `rdy` low. Later stores are not reordered around it.

## Timing
- Request path is zero latency (combinational).
- Response latency is 1 cycle: `xcel_resp_val_o` is high the cycle after `returned_v_i`.
- `xcel_resp_val_o` is high for exactly one cycle per valid return. Back-to-back returns give back-to-back responses.
- Reset:
  - `inuse_r` = 0, `outstanding_r` = 0, `err_r` = 0.
  - `xcel_resp_val_o` = 0; resp opq and data = 0.
- Outputs during reset follow the combinational rules with `full` = 0. `out_v_o` is qualified by `xcel_req_val_i`; the accelerator is also in reset.
- Reset mid-operation drops all outstanding entries. Later returns of pre-reset IDs set `err_o`.
- The `opq_r` table needs no reset and is read only for in-use entries.

## Test plan
- **Single load:**
  - Stimulus: load opq = 0x5A, addr 0x1000; return ID 0 with data 0xDEADBEEF two cycles later.
  - Expect: `out_load_id_o` = 0; `xcel_resp_val_o` one cycle after the return with opq 0x5A and data 0xDEADBEEF; `outstanding_o` 0→1→0.
- **Fill and block:**
  - Stimulus: 8 loads (opq 0..7) with `out_ready_i` = 1, then a 9th load; then return ID 3.
  - Expect: IDs 0..7 issued; 9th sees `xcel_req_rdy_o` = 0 and `out_v_o` = 0. After returning ID 3, the 9th issues the following cycle with ID 3.
- **Store bypass when full:**
  - Stimulus: with all 8 entries in use, a store with data 0x11 arrives.
  - Expect: `out_v_o` = 1, `xcel_req_rdy_o` = 1, `outstanding_o` stays 8.
- **Out-of-order returns:**
  - Stimulus: issue 3 loads (opq 0xA, 0xB, 0xC); return IDs 2, 0, 1 on consecutive cycles.
  - Expect: responses on consecutive cycles with opq 0xC, 0xA, 0xB.
- **Simultaneous fire and return:**
  - Stimulus: with entries 0–7 full except ID 7, a load fires in the same cycle ID 2 returns.
  - Expect: the new load gets ID 7 (not 2); `outstanding_o` unchanged.
- **Error and reset:**
  - Stimulus: return ID 5 when it is free, or ID 9 with `els_p` = 8.
  - Expect: `err_o` = 1 next cycle and sticky; no response.
  - Stimulus: reset mid-traffic.
  - Expect: `err_o` = 0, `outstanding_o` = 0, `xcel_resp_val_o` = 0.

Source files
------------

// File: rtl/brg_xcel_load_tracker.sv
// Load tracker between an accelerator memory port and a manycore endpoint:
// allocates load IDs from a free pool, remembers opaque tags, and returns responses.
module brg_xcel_load_tracker #(
   parameter int data_width_p    = 32,
   parameter int addr_width_p    = 32,
   parameter int load_id_width_p = 11,
   parameter int opq_width_p     = 8,
   parameter int els_p           = 8
) (
   input  logic                         clk_i,
   input  logic                         reset_i,

   input  logic                         xcel_req_val_i,
   output logic                         xcel_req_rdy_o,
   input  logic                         xcel_req_type_i,
   input  logic [addr_width_p-1:0]      xcel_req_addr_i,
   input  logic [data_width_p-1:0]      xcel_req_data_i,
   input  logic [data_width_p/8-1:0]    xcel_req_mask_i,
   input  logic [opq_width_p-1:0]       xcel_req_opq_i,

   output logic                         out_v_o,
   input  logic                         out_ready_i,
   output logic                         out_type_o,
   output logic [addr_width_p-1:0]      out_addr_o,
   output logic [data_width_p-1:0]      out_data_o,
   output logic [data_width_p/8-1:0]    out_mask_o,
   output logic [load_id_width_p-1:0]   out_load_id_o,

   input  logic                         returned_v_i,
   input  logic [load_id_width_p-1:0]   returned_load_id_i,
   input  logic [data_width_p-1:0]      returned_data_i,

   output logic                         xcel_resp_val_o,
   output logic [opq_width_p-1:0]       xcel_resp_opq_o,
   output logic [data_width_p-1:0]      xcel_resp_data_o,

   output logic [$clog2(els_p+1)-1:0]   outstanding_o,
   output logic                         err_o
);

   localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam logic [load_id_width_p:0] els_lp = (load_id_width_p + 1)'(els_p);

   logic [els_p-1:0]        inuse_q, inuse_d;
   logic [opq_width_p-1:0]  opq_q [els_p];
   logic                    resp_val_q, resp_val_d;
   logic [opq_width_p-1:0]  resp_opq_q, resp_opq_d;
   logic [data_width_p-1:0] resp_data_q, resp_data_d;
   logic [cnt_w_lp-1:0]     outstanding_q, outstanding_d;
   logic                    err_q, err_d;

   logic [idx_w_lp-1:0]     alloc_idx;
   logic                    alloc_found;
   logic                    full;
   logic                    req_ok;
   logic                    load_fire;
   logic [idx_w_lp-1:0]     ret_idx;
   logic                    ret_in_range;
   logic                    ret_hit;

   // Lowest free entry, from registered state only.
   always_comb begin
      alloc_idx   = '0;
      alloc_found = 1'b0;
      for (int unsigned i = 0; i < els_p; i++) begin
         if (!inuse_q[i] && !alloc_found) begin
            alloc_idx   = idx_w_lp'(i);
            alloc_found = 1'b1;
         end
      end
   end

   // Reset masks the full condition so outputs are defined while the state is being cleared.
   assign full      = (&inuse_q) & ~reset_i;
   assign req_ok    = xcel_req_type_i | ~full;
   assign load_fire = xcel_req_val_i & xcel_req_rdy_o & ~xcel_req_type_i;

   assign out_v_o        = xcel_req_val_i & req_ok;
   assign xcel_req_rdy_o = out_ready_i & req_ok;
   assign out_type_o     = xcel_req_type_i;
   assign out_addr_o     = xcel_req_addr_i;
   assign out_data_o     = xcel_req_data_i;
   assign out_mask_o     = xcel_req_mask_i;
   assign out_load_id_o  = xcel_req_type_i ? '0 : load_id_width_p'(alloc_idx);

   assign ret_idx      = returned_load_id_i[idx_w_lp-1:0];
   assign ret_in_range = {1'b0, returned_load_id_i} < els_lp;
   assign ret_hit      = returned_v_i & ret_in_range & inuse_q[ret_idx];

   always_comb begin
      inuse_d = inuse_q;
      if (ret_hit)   inuse_d[ret_idx]   = 1'b0;
      if (load_fire) inuse_d[alloc_idx] = 1'b1;

      outstanding_d = outstanding_q;
      case ({load_fire, ret_hit})
         2'b10:   outstanding_d = outstanding_q + cnt_w_lp'(1);
         2'b01:   outstanding_d = outstanding_q - cnt_w_lp'(1);
         default: outstanding_d = outstanding_q;
      endcase

      err_d       = err_q | (returned_v_i & ~ret_hit);
      resp_val_d  = ret_hit;
      resp_opq_d  = ret_hit ? opq_q[ret_idx] : resp_opq_q;
      resp_data_d = ret_hit ? returned_data_i : resp_data_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         inuse_q       <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         resp_val_q    <= 1'b0;
         resp_opq_q    <= '0;
         resp_data_q   <= '0;
      end else begin
         inuse_q       <= inuse_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         resp_val_q    <= resp_val_d;
         resp_opq_q    <= resp_opq_d;
         resp_data_q   <= resp_data_d;
      end
   end

   // Tag table is only read for in-use entries, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (load_fire) opq_q[alloc_idx] <= xcel_req_opq_i;
   end

   assign xcel_resp_val_o  = resp_val_q;
   assign xcel_resp_opq_o  = resp_opq_q;
   assign xcel_resp_data_o = resp_data_q;
   assign outstanding_o    = outstanding_q;
   assign err_o            = err_q;

endmodule
